// File: rtl/instr_loader_if.sv
// Byte-stream input and instruction-memory write bundle for instr_loader.
// master = byte source / memory side, slave = the loader itself.
interface instr_loader_if #(
  parameter int ADDR_W = 3,
  parameter int WORD_W = 32
);
  logic              start;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;
  logic [ADDR_W:0]   word_cnt;
  logic              done;
  logic              err;

  modport master (
    output start, in_data, in_valid,
    input  in_ready, wr_en, wr_addr, wr_data, word_cnt, done, err
  );

  modport slave (
    input  start, in_data, in_valid,
    output in_ready, wr_en, wr_addr, wr_data, word_cnt, done, err
  );
endinterface

// File: rtl/instr_loader.sv
// Packs a big-endian byte stream into 32-bit words and writes DEPTH words to instruction memory.
// Define LOADER_CHECKSUM_EN to add a trailing XOR checksum byte that drives err.
module instr_loader #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int WORD_W = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  instr_loader_if.slave bus
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_DONE = 2'd2, S_CHECK = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_DONE = 2'd2} state_t;
`endif

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic                r_in_ready;
  logic                w_in_ready_next;
  logic                w_accept;
  logic                w_word_fire;
  logic [1:0]          r_byte_cnt;
  logic [23:0]         r_shift;
  logic [ADDR_W-1:0]   r_word_idx;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [WORD_W-1:0]   r_wr_data;
  logic [ADDR_W:0]     r_word_cnt;
  logic                r_done;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          r_xor;
  logic                r_err;
`endif

  // start always wins over a byte presented in the same cycle
  always_comb begin
    w_state_next    = r_state;
    w_accept        = bus.in_valid && r_in_ready && !bus.start;
    w_word_fire     = w_accept && (r_state == S_LOAD) && (r_byte_cnt == 2'd3);
    w_in_ready_next = 1'b0;
    case (r_state)
      S_IDLE: if (bus.start) w_state_next = S_LOAD;
      S_LOAD: begin
        if (bus.start) begin
          w_state_next = S_LOAD;
        end else if (w_word_fire && (r_word_idx == LAST_IDX)) begin
`ifdef LOADER_CHECKSUM_EN
          w_state_next = S_CHECK;
`else
          w_state_next = S_DONE;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (bus.start)     w_state_next = S_LOAD;
        else if (w_accept) w_state_next = S_DONE;
      end
`endif
      S_DONE: if (bus.start) w_state_next = S_LOAD;
      default: w_state_next = S_IDLE;
    endcase
`ifdef LOADER_CHECKSUM_EN
    w_in_ready_next = (w_state_next == S_LOAD) || (w_state_next == S_CHECK);
`else
    w_in_ready_next = (w_state_next == S_LOAD);
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_in_ready <= w_in_ready_next;
    end
  end

  // wr_data/wr_addr are separate from the shift register so they hold while the next word arrives
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_byte_cnt <= 2'd0;
      r_shift    <= 24'd0;
      r_word_idx <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_word_cnt <= '0;
      r_done     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_xor      <= 8'd0;
      r_err      <= 1'b0;
`endif
    end else begin
      r_wr_en <= w_word_fire;
      if (bus.start) begin
        r_byte_cnt <= 2'd0;
        r_shift    <= 24'd0;
        r_word_idx <= '0;
        r_wr_addr  <= '0;
        r_word_cnt <= '0;
        r_done     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
        r_xor      <= 8'd0;
        r_err      <= 1'b0;
`endif
      end else begin
        if (w_accept && (r_state == S_LOAD)) begin
`ifdef LOADER_CHECKSUM_EN
          r_xor <= r_xor ^ bus.in_data;
`endif
          if (r_byte_cnt == 2'd3) begin
            r_wr_data  <= {r_shift, bus.in_data};
            r_wr_addr  <= r_word_idx;
            r_word_idx <= r_word_idx + ADDR_W'(1);
            r_word_cnt <= r_word_cnt + (ADDR_W + 1)'(1);
            r_byte_cnt <= 2'd0;
          end else begin
            r_shift    <= {r_shift[15:0], bus.in_data};
            r_byte_cnt <= r_byte_cnt + 2'd1;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        if (w_accept && (r_state == S_CHECK)) r_err <= (bus.in_data != r_xor);
`endif
        if ((w_state_next == S_DONE) && (r_state != S_DONE)) r_done <= 1'b1;
      end
    end
  end

  assign bus.in_ready = r_in_ready;
  assign bus.wr_en    = r_wr_en;
  assign bus.wr_addr  = r_wr_addr;
  assign bus.wr_data  = r_wr_data;
  assign bus.word_cnt = r_word_cnt;
  assign bus.done     = r_done;
`ifdef LOADER_CHECKSUM_EN
  assign bus.err      = r_err;
`else
  assign bus.err      = 1'b0;
`endif

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: packing, streaming, gaps, restart, async reset and optional checksum.
module tb_instr_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_mis = 0;
  int   wr_seen = 0;
  int   base;

  always #5 clk = ~clk;

  instr_loader_if bus ();

  instr_loader dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  logic [31:0] words [8] = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10,
                             32'h11121314, 32'h15161718, 32'h191A1B1C, 32'h1D1E1F20};

  always @(negedge clk) if (bus.wr_en === 1'b1) wr_seen <= wr_seen + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%08h", tag, got);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge, valid left high.
  task automatic send_byte(input logic [7:0] b);
    int t;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    t = 0;
    while (bus.in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check_val("rdy_timeout", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) send_byte(w[31-8*b -: 8]);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    repeat (2) @(negedge clk);
    check_val("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check_val("rst_wr_en", 32'(bus.wr_en), 32'd0);
    check_val("rst_done", 32'(bus.done), 32'd0);
    check_val("rst_err", 32'(bus.err), 32'd0);
    check_val("rst_word_cnt", 32'(bus.word_cnt), 32'd0);
    check_val("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    check_val("rst_wr_data", bus.wr_data, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("idle_in_ready", 32'(bus.in_ready), 32'd0);

    // 1: single word
    pulse_start();
    check_val("s1_in_ready", 32'(bus.in_ready), 32'd1);
    send_word(32'h80221800);
    check_val("s1_wr_en", 32'(bus.wr_en), 32'd1);
    check_val("s1_wr_addr", 32'(bus.wr_addr), 32'd0);
    check_val("s1_wr_data", bus.wr_data, 32'h80221800);
    check_val("s1_word_cnt", 32'(bus.word_cnt), 32'd1);
    idle(1);
    check_val("s1_wr_en_pulse", 32'(bus.wr_en), 32'd0);

    // 2: full continuous load
    base = wr_seen;
    pulse_start();
    check_val("s2_cnt_clr", 32'(bus.word_cnt), 32'd0);
    for (int w = 0; w < 8; w++) begin
      send_word(words[w]);
      check_val($sformatf("s2_wr_en%0d", w), 32'(bus.wr_en), 32'd1);
      check_val($sformatf("s2_addr%0d", w), 32'(bus.wr_addr), 32'(w));
      check_val($sformatf("s2_data%0d", w), bus.wr_data, words[w]);
      check_val($sformatf("s2_cnt%0d", w), 32'(bus.word_cnt), 32'(w + 1));
    end
`ifdef LOADER_CHECKSUM_EN
    check_val("s2_done_wait", 32'(bus.done), 32'd0);
    check_val("s2_check_ready", 32'(bus.in_ready), 32'd1);
    send_byte(8'h20);
    check_val("s2_err", 32'(bus.err), 32'd0);
`endif
    check_val("s2_done", 32'(bus.done), 32'd1);
    check_val("s2_ready_off", 32'(bus.in_ready), 32'd0);
    idle(2);
    check_val("s2_wr_count", 32'(wr_seen - base), 32'd8);
    check_val("s2_done_hold", 32'(bus.done), 32'd1);
    check_val("s2_ready_hold", 32'(bus.in_ready), 32'd0);

    // 3: gaps in in_valid
    base = wr_seen;
    pulse_start();
    check_val("s3_done_clr", 32'(bus.done), 32'd0);
    send_byte(8'h80); idle(2);
    send_byte(8'h22); idle(2);
    send_byte(8'h18); idle(2);
    check_val("s3_no_early_wr", 32'(wr_seen - base), 32'd0);
    check_val("s3_cnt_hold", 32'(bus.word_cnt), 32'd0);
    send_byte(8'h00);
    check_val("s3_wr_en", 32'(bus.wr_en), 32'd1);
    check_val("s3_wr_data", bus.wr_data, 32'h80221800);
    check_val("s3_wr_addr", 32'(bus.wr_addr), 32'd0);
    idle(2);
    check_val("s3_wr_count", 32'(wr_seen - base), 32'd1);

    // 4: restart discards partial word; byte with start is dropped
    base = wr_seen;
    pulse_start();
    send_word(32'hA0B0C0D0);
    check_val("s4_w0_data", bus.wr_data, 32'hA0B0C0D0);
    send_word(32'h11223344);
    check_val("s4_w1_addr", 32'(bus.wr_addr), 32'd1);
    check_val("s4_w1_data", bus.wr_data, 32'h11223344);
    send_byte(8'h55);
    send_byte(8'h66);
    bus.start = 1'b1;
    bus.in_data = 8'h77;
    @(negedge clk);
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    check_val("s4_cnt_clr", 32'(bus.word_cnt), 32'd0);
    check_val("s4_no_wr", 32'(bus.wr_en), 32'd0);
    send_word(32'h11223344);
    check_val("s4_re_addr", 32'(bus.wr_addr), 32'd0);
    check_val("s4_re_data", bus.wr_data, 32'h11223344);
    check_val("s4_re_cnt", 32'(bus.word_cnt), 32'd1);
    idle(2);
    check_val("s4_wr_count", 32'(wr_seen - base), 32'd3);

    // 5: asynchronous reset mid-word
    pulse_start();
    base = wr_seen;
    for (int w = 0; w < 3; w++) send_word(words[w]);
    send_byte(8'hAA);
    send_byte(8'hBB);
    check_val("s5_cnt_pre", 32'(bus.word_cnt), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check_val("s5_rst_ready", 32'(bus.in_ready), 32'd0);
    check_val("s5_rst_wr_en", 32'(bus.wr_en), 32'd0);
    check_val("s5_rst_done", 32'(bus.done), 32'd0);
    check_val("s5_rst_cnt", 32'(bus.word_cnt), 32'd0);
    check_val("s5_rst_addr", 32'(bus.wr_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_data = 8'h33;
    bus.in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check_val("s5_idle_ready", 32'(bus.in_ready), 32'd0);
    check_val("s5_idle_cnt", 32'(bus.word_cnt), 32'd0);
    check_val("s5_wr_count", 32'(wr_seen - base), 32'd3);
    idle(1);
    pulse_start();
    check_val("s5_start_ready", 32'(bus.in_ready), 32'd1);

`ifdef LOADER_CHECKSUM_EN
    // 6: checksum good then bad
    idle(1);
    pulse_start();
    for (int i = 0; i < 32; i++) send_byte(8'h01);
    check_val("s6_done_wait", 32'(bus.done), 32'd0);
    check_val("s6_check_ready", 32'(bus.in_ready), 32'd1);
    send_byte(8'h00);
    check_val("s6_good_done", 32'(bus.done), 32'd1);
    check_val("s6_good_err", 32'(bus.err), 32'd0);
    check_val("s6_ready_off", 32'(bus.in_ready), 32'd0);
    idle(1);
    pulse_start();
    for (int i = 0; i < 32; i++) send_byte(8'h01);
    send_byte(8'h5A);
    check_val("s6_bad_done", 32'(bus.done), 32'd1);
    check_val("s6_bad_err", 32'(bus.err), 32'd1);
    idle(1);
    pulse_start();
    check_val("s6_err_clr", 32'(bus.err), 32'd0);
    check_val("s6_done_clr", 32'(bus.done), 32'd0);
`endif

    idle(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Writer-side front end for instruction memory: receives a program as a byte stream over a valid/ready handshake.
- Packs each group of four bytes into a 32-bit instruction word and drives a one-cycle write into instruction memory at an auto-incrementing address.
- Raises done once all DEPTH words are written; the CPU is held off until then.
- Sits between the host/debug byte source and the instruction memory write port.

Parameters:
DEPTH, 8, number of instruction words to load (instruction address space is 3 bits)
ADDR_W, 3, width of wr_addr; DEPTH must equal 2**ADDR_W
WORD_W, 32, instruction word width; fixed at 4 bytes

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low (0 = reset)
start  input  1  one-cycle pulse; begins a new load from address 0
in_data  input  8  program byte
in_valid  input  1  in_data valid
in_ready  output  1  loader accepts a byte this cycle
wr_en  output  1  instruction memory write strobe, one cycle per word
wr_addr  output  ADDR_W  instruction memory write address
wr_data  output  WORD_W  assembled instruction word
word_cnt  output  ADDR_W+1  number of words written in the current load
done  output  1  all DEPTH words written; level, held until next start
err  output  1  checksum mismatch (see Optional Feature); level

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - in_ready, wr_en, done and err are 0.
  - wr_addr, wr_data, word_cnt, the byte counter and the shift register are 0.
- Byte accepted on a rising clk edge when in_valid=1 and in_ready=1.
- in_ready=1 only in LOAD (and CHECK when enabled); it is a registered state decode, independent of in_valid.
- Packing is big-endian: the 1st byte goes to bits 31:24, the 2nd to 23:16, the 3rd to 15:8, the 4th to 7:0.
- On acceptance of the 4th byte:
  - Next cycle: wr_en=1 for exactly one cycle, with wr_data=packed word and wr_addr=current word index.
  - word_cnt increments in the same cycle.
- Latency: one clock from accepting the 4th byte to wr_en.
- Bytes of the next word may be accepted during the wr_en cycle; wr_data/wr_addr are registered separately from the shift register, so they hold stable.
- Transitions:
  - IDLE: start=1 -> LOAD; counters, word_cnt, done and err are cleared.
  - LOAD: 4th byte of word DEPTH-1 accepted -> DONE (or CHECK when enabled). The final wr_en fires in the first cycle of DONE/CHECK.
  - LOAD: start=1 -> restart in LOAD; byte counter, address and word_cnt go to 0. A partial word is discarded and not written. A byte presented in the same cycle is not accepted.
  - DONE: done=1, in_ready=0; start=1 -> LOAD (cleared as above).
- wr_addr wraps from DEPTH-1 to 0 only via restart; never beyond DEPTH words per load.
- start with in_valid in IDLE or DONE: start wins; the byte is not accepted, because in_ready=0 that cycle.
- in_valid dropping mid-word: the byte counter holds; no timeout.
- rst asserted mid-load: immediate return to reset values. Instruction memory contents are untouched. An in-flight wr_en is cancelled asynchronously.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- When defined:
  - A running XOR of all 4*DEPTH accepted program bytes is kept.
  - After the last word the FSM enters CHECK, accepting exactly one extra checksum byte.
  - err=1 if that byte differs from the running XOR, else err=0. Next state is DONE.
  - done does not rise until the checksum byte is accepted. All words are still written.
- When not defined:
  - No CHECK state, no XOR register.
  - err is tied to 0.
  - done rises in the cycle of the final wr_en.

Test Plan:
1. Reset, start, stream 0x80,0x22,0x18,0x00 -> one cycle after the 4th byte: wr_en=1, wr_addr=0, wr_data=0x80221800, word_cnt=1.
2. Stream 32 bytes continuously, with in_valid=1 every cycle:
   - 8 wr_en pulses at addresses 0..7.
   - done=1 in the cycle of the 8th wr_en (no CHECKSUM_EN); in_ready=0 afterwards.
3. Backpressure/gaps: toggle in_valid 1,0,0,1 between bytes -> identical wr_data values to scenario 1; no spurious wr_en.
4. Send 6 bytes, then pulse start -> no write for the partial word. A subsequent 0x11,0x22,0x33,0x44 writes 0x11223344 at addr 1 after the first word, and at addr 0 after restart.
5. Assert rst=0 asynchronously mid-word (byte 2 of word 3) -> in_ready, wr_en, done and word_cnt go to 0 without a clock edge; the FSM stays IDLE until start.
6. With LOADER_CHECKSUM_EN, 32 bytes of 0x01:
   - A checksum byte of 0x00 gives done=1, err=0.
   - Rerunning with a checksum byte of 0x5A gives done=1, err=1.
   - start clears err.
